// File: rtl/store_buffer_coalesce_pkg.sv
// Shared types for the post-commit store buffer.
//   sb_state_t      drain FSM state
//   store_buffer_t  one buffered store (valid, word address, lane data, byte mask)
//   mem_rqst_t      write request toward the D-cache
//   mem_resp_t      D-cache response; .resp completes the outstanding write
package store_buffer_coalesce_pkg;

    localparam int NUM_STORE_BUFFER_ENTRIES = 2;

    typedef enum logic {
        SB_IDLE = 1'b0,
        SB_BUSY = 1'b1
    } sb_state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } store_buffer_t;

    typedef struct packed {
        logic [31:0] addr;
        logic        rd_en;
        logic        wr_en;
        logic [3:0]  mask;
        logic [31:0] wdata;
    } mem_rqst_t;

    typedef struct packed {
        logic        resp;
        logic [31:0] rdata;
    } mem_resp_t;

    function automatic logic same_word(input logic [31:0] a, input logic [31:0] b);
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/store_buffer_coalesce_fwd_merge.sv
// sb_fwd_merge: combinational store-to-load byte forwarding.
// Walks the occupied entries oldest (head) to youngest so a younger store's
// byte overrides an older one; the in-flight head takes part like any other.
//   entries   buffer contents
//   head      index of the oldest entry
//   count     number of occupied entries
//   q_addr    load address, [31:2] compared
//   q_mask    bytes the load needs
//   byte_data forwarded bytes, lanes not covered are 0
//   byte_cov  needed bytes found in the buffer
module sb_fwd_merge
    import store_buffer_coalesce_pkg::*;
#(
    parameter int DEPTH = NUM_STORE_BUFFER_ENTRIES,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  store_buffer_t [DEPTH-1:0] entries,
    input  logic [PTR_W-1:0]          head,
    input  logic [CNT_W-1:0]          count,
    input  logic [31:0]               q_addr,
    input  logic [3:0]                q_mask,
    output logic [31:0]               byte_data,
    output logic [3:0]                byte_cov
);

    logic [PTR_W-1:0] idx;

    always_comb begin
        byte_data = '0;
        byte_cov  = '0;
        idx       = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + PTR_W'(i);
            if ((CNT_W'(i) < count) && entries[idx].valid &&
                same_word(entries[idx].addr, q_addr)) begin
                for (int b = 0; b < 4; b++) begin
                    if (entries[idx].mask[b] && q_mask[b]) begin
                        byte_data[8*b +: 8] = entries[idx].wdata[8*b +: 8];
                        byte_cov[b]         = 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: rtl/store_buffer_coalesce.sv
// store_buffer_coalesce: circular FIFO of committed stores drained one at a
// time to the D-cache, with optional same-word merging into the youngest entry
// and store-to-load forwarding.
//   clk, rst                 clock, synchronous active-high reset
//   enq_valid/ready          committed store handshake
//   enq_addr/wdata/mask      word address, lane-shifted data, byte enables
//   ld_query_valid/addr/mask load probe
//   fwd_hit/data/stall       forwarding result
//   dmem_rqst/dmem_resp      D-cache write port
//   empty, count             occupancy
//
// state   | meaning
// SB_IDLE | no write outstanding; launches the head next edge if count>0
// SB_BUSY | head write presented to dmem, held until dmem_resp.resp
module store_buffer_coalesce
    import store_buffer_coalesce_pkg::*;
#(
    parameter int DEPTH    = NUM_STORE_BUFFER_ENTRIES,
    parameter bit COALESCE = 1'b1,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq_valid,
    output logic             enq_ready,
    input  logic [31:0]      enq_addr,
    input  logic [31:0]      enq_wdata,
    input  logic [3:0]       enq_mask,
    input  logic             ld_query_valid,
    input  logic [31:0]      ld_query_addr,
    input  logic [3:0]       ld_query_mask,
    output logic             fwd_hit,
    output logic [31:0]      fwd_data,
    output logic             fwd_stall,
    output mem_rqst_t        dmem_rqst,
    input  mem_resp_t        dmem_resp,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    store_buffer_t [DEPTH-1:0] entries_q, entries_d;
    logic [PTR_W-1:0]          head_q, head_d, tail_q, tail_d, tail_m1;
    logic [CNT_W-1:0]          count_q, count_d;
    sb_state_t                 state_q, state_d;
    logic                      coalesce_hit, enq_fire, pop;
    logic [31:0]               byte_data;
    logic [3:0]                byte_cov;

    // Merging into the entry currently being written would change data under
    // an outstanding request, so the in-flight head is excluded.
    always_comb begin
        tail_m1      = tail_q - PTR_W'(1);
        coalesce_hit = COALESCE && (count_q != '0) &&
                       same_word(entries_q[tail_m1].addr, enq_addr) &&
                       !((state_q == SB_BUSY) && (tail_m1 == head_q));
        enq_ready    = (count_q < CNT_W'(DEPTH)) || coalesce_hit;
        enq_fire     = enq_valid && enq_ready;
        pop          = (state_q == SB_BUSY) && dmem_resp.resp;
    end

    always_comb begin
        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        state_d   = state_q;

        if (enq_fire) begin
            if (coalesce_hit) begin
                for (int b = 0; b < 4; b++) begin
                    if (enq_mask[b]) begin
                        entries_d[tail_m1].wdata[8*b +: 8] = enq_wdata[8*b +: 8];
                    end
                end
                entries_d[tail_m1].mask = entries_q[tail_m1].mask | enq_mask;
            end else begin
                entries_d[tail_q].valid = 1'b1;
                entries_d[tail_q].addr  = enq_addr;
                entries_d[tail_q].wdata = enq_wdata;
                entries_d[tail_q].mask  = enq_mask;
                tail_d                  = tail_q + PTR_W'(1);
                count_d                 = count_d + CNT_W'(1);
            end
        end

        if (pop) begin
            entries_d[head_q].valid = 1'b0;
            head_d                  = head_q + PTR_W'(1);
            count_d                 = count_d - CNT_W'(1);
        end

        case (state_q)
            SB_IDLE: if (count_q != '0) state_d = SB_BUSY;
            SB_BUSY: if (dmem_resp.resp) state_d = SB_IDLE;
            default: state_d = SB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            entries_q <= '0;
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            state_q   <= SB_IDLE;
        end else begin
            entries_q <= entries_d;
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            state_q   <= state_d;
        end
    end

    always_comb begin
        dmem_rqst = '0;
        if (state_q == SB_BUSY) begin
            dmem_rqst.addr  = {entries_q[head_q].addr[31:2], 2'b00};
            dmem_rqst.wr_en = 1'b1;
            dmem_rqst.mask  = entries_q[head_q].mask;
            dmem_rqst.wdata = entries_q[head_q].wdata;
        end
    end

    sb_fwd_merge #(.DEPTH(DEPTH)) u_fwd_merge (
        .entries   (entries_q),
        .head      (head_q),
        .count     (count_q),
        .q_addr    (ld_query_addr),
        .q_mask    (ld_query_mask),
        .byte_data (byte_data),
        .byte_cov  (byte_cov)
    );

    always_comb begin
        fwd_hit   = ld_query_valid && (byte_cov == ld_query_mask);
        fwd_stall = ld_query_valid && (byte_cov != 4'h0) && !fwd_hit;
        fwd_data  = ld_query_valid ? byte_data : 32'h0;
        empty     = (count_q == '0);
        count     = count_q;
    end

    a_enq_ready: assert property (@(posedge clk) disable iff (rst) enq_valid |-> enq_ready);
    a_enq_mask:  assert property (@(posedge clk) disable iff (rst) enq_valid |-> (enq_mask != 4'h0));
    a_count:     assert property (@(posedge clk) disable iff (rst) count_q <= CNT_W'(DEPTH));

endmodule

// File: tb/tb_store_buffer_coalesce.sv
module tb_store_buffer_coalesce;
    import store_buffer_coalesce_pkg::*;

    logic        clk;
    logic        rst;
    logic        enq_valid, enq_valid_nc;
    logic        enq_ready, enq_ready_nc;
    logic [31:0] enq_addr, enq_wdata;
    logic [3:0]  enq_mask;
    logic        ld_query_valid;
    logic [31:0] ld_query_addr;
    logic [3:0]  ld_query_mask;
    logic        fwd_hit, fwd_stall, fwd_hit_nc, fwd_stall_nc;
    logic [31:0] fwd_data, fwd_data_nc;
    mem_rqst_t   dmem_rqst, dmem_rqst_nc;
    mem_resp_t   dmem_resp, dmem_resp_nc;
    logic        empty, empty_nc;
    logic [1:0]  count, count_nc;

    int n_vec;
    int n_bad;

    store_buffer_coalesce #(.DEPTH(2), .COALESCE(1'b1)) u_dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready),
        .enq_addr(enq_addr), .enq_wdata(enq_wdata), .enq_mask(enq_mask),
        .ld_query_valid(ld_query_valid), .ld_query_addr(ld_query_addr), .ld_query_mask(ld_query_mask),
        .fwd_hit(fwd_hit), .fwd_data(fwd_data), .fwd_stall(fwd_stall),
        .dmem_rqst(dmem_rqst), .dmem_resp(dmem_resp),
        .empty(empty), .count(count)
    );

    store_buffer_coalesce #(.DEPTH(2), .COALESCE(1'b0)) u_dut_nc (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid_nc), .enq_ready(enq_ready_nc),
        .enq_addr(enq_addr), .enq_wdata(enq_wdata), .enq_mask(enq_mask),
        .ld_query_valid(ld_query_valid), .ld_query_addr(ld_query_addr), .ld_query_mask(ld_query_mask),
        .fwd_hit(fwd_hit_nc), .fwd_data(fwd_data_nc), .fwd_stall(fwd_stall_nc),
        .dmem_rqst(dmem_rqst_nc), .dmem_resp(dmem_resp_nc),
        .empty(empty_nc), .count(count_nc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [31:0] ea;
        logic [31:0] ed;
        logic [3:0]  em;
        logic        rsp;
        logic        qv;
        logic [31:0] qa;
        logic [3:0]  qm;
        logic        x_rdy;
        logic        x_emp;
        logic [1:0]  x_cnt;
        logic        x_wr;
        logic [31:0] x_wa;
        logic [3:0]  x_wm;
        logic [31:0] x_wd;
        logic        x_hit;
        logic        x_stl;
        logic [31:0] x_fd;
    } vec_t;

    vec_t tbl [21];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        enq_valid      = 1'b0;
        enq_valid_nc   = 1'b0;
        enq_addr       = 32'h0;
        enq_wdata      = 32'h0;
        enq_mask       = 4'h0;
        ld_query_valid = 1'b0;
        ld_query_addr  = 32'h0;
        ld_query_mask  = 4'h0;
        dmem_resp      = '0;
        dmem_resp_nc   = '0;
    endtask

    initial begin
        vec_t t;
        logic ok;
        n_vec = 0;
        n_bad = 0;

        //           ev    ea            ed            em    rsp   qv    qa            qm      rdy   emp   cnt   wr    wa            wm    wd            hit   stl   fd
        // single store, launched two cycles after enqueue, drained on resp
        tbl[0]  = '{1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        4'h0,   1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, 32'h100,      32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 32'h0,        4'h0,   1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[2]  = '{1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        4'h0,   1'b1, 1'b0, 2'd1, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[3]  = '{1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 1'b1, 32'h100,      4'hF,   1'b1, 1'b0, 2'd1, 1'b1, 32'h100,      4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'hDEADBEEF};
        tbl[4]  = '{1'b0, 32'h0,        32'h0,        4'h0, 1'b1, 1'b0, 32'h0,        4'h0,   1'b1, 1'b0, 2'd1, 1'b1, 32'h100,      4'hF, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0};
        tbl[5]  = '{1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        4'h0,   1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        // coalesce of two byte stores into one entry (head pointer now 1)
        tbl[6]  = '{1'b1, 32'h200,      32'h000000AA, 4'h1, 1'b0, 1'b0, 32'h0,        4'h0,   1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[7]  = '{1'b1, 32'h200,      32'h0000BB00, 4'h2, 1'b0, 1'b0, 32'h0,        4'h0,   1'b1, 1'b0, 2'd1, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[8]  = '{1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 1'b1, 32'h200,      4'h3,   1'b1, 1'b0, 2'd1, 1'b1, 32'h200,      4'h3, 32'h0000BBAA, 1'b1, 1'b0, 32'h0000BBAA};
        tbl[9]  = '{1'b0, 32'h0,        32'h0,        4'h0, 1'b1, 1'b0, 32'h0,        4'h0,   1'b1, 1'b0, 2'd1, 1'b1, 32'h200,      4'h3, 32'h0000BBAA, 1'b0, 1'b0, 32'h0};
        tbl[10] = '{1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        4'h0,   1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        // fill while dmem stalls, full-buffer ready, coalesce into full buffer, forwarding
        tbl[11] = '{1'b1, 32'h300,      32'h33333333, 4'hF, 1'b0, 1'b0, 32'h0,        4'h0,   1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[12] = '{1'b1, 32'h400,      32'h00000044, 4'h1, 1'b0, 1'b0, 32'h0,        4'h0,   1'b1, 1'b0, 2'd1, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[13] = '{1'b0, 32'h500,      32'h0,        4'h0, 1'b0, 1'b1, 32'h300,      4'hF,   1'b0, 1'b0, 2'd2, 1'b1, 32'h300,      4'hF, 32'h33333333, 1'b1, 1'b0, 32'h33333333};
        tbl[14] = '{1'b0, 32'h400,      32'h0,        4'h0, 1'b0, 1'b1, 32'h400,      4'h3,   1'b1, 1'b0, 2'd2, 1'b1, 32'h300,      4'hF, 32'h33333333, 1'b0, 1'b1, 32'h00000044};
        tbl[15] = '{1'b1, 32'h400,      32'h00005500, 4'h2, 1'b0, 1'b0, 32'h0,        4'h0,   1'b1, 1'b0, 2'd2, 1'b1, 32'h300,      4'hF, 32'h33333333, 1'b0, 1'b0, 32'h0};
        tbl[16] = '{1'b0, 32'h0,        32'h0,        4'h0, 1'b1, 1'b1, 32'h400,      4'h3,   1'b0, 1'b0, 2'd2, 1'b1, 32'h300,      4'hF, 32'h33333333, 1'b1, 1'b0, 32'h00005544};
        tbl[17] = '{1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        4'h0,   1'b1, 1'b0, 2'd1, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0};
        tbl[18] = '{1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 1'b0, 32'h0,        4'h0,   1'b1, 1'b0, 2'd1, 1'b1, 32'h400,      4'h3, 32'h00005544, 1'b0, 1'b0, 32'h0};
        tbl[19] = '{1'b0, 32'h0,        32'h0,        4'h0, 1'b1, 1'b0, 32'h0,        4'h0,   1'b1, 1'b0, 2'd1, 1'b1, 32'h400,      4'h3, 32'h00005544, 1'b0, 1'b0, 32'h0};
        tbl[20] = '{1'b0, 32'h0,        32'h0,        4'h0, 1'b0, 1'b1, 32'h300,      4'hF,   1'b1, 1'b1, 2'd0, 1'b0, 32'h0,        4'h0, 32'h0,        1'b0, 1'b0, 32'h0};

        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 21; i++) begin
            t = tbl[i];
            if (i > 0) @(negedge clk);
            enq_valid      = t.ev;
            enq_addr       = t.ea;
            enq_wdata      = t.ed;
            enq_mask       = t.em;
            dmem_resp.resp = t.rsp;
            ld_query_valid = t.qv;
            ld_query_addr  = t.qa;
            ld_query_mask  = t.qm;
            #2;
            ok = (enq_ready === t.x_rdy) && (empty === t.x_emp) && (count === t.x_cnt) &&
                 (dmem_rqst.wr_en === t.x_wr) && (dmem_rqst.rd_en === 1'b0) &&
                 (dmem_rqst.addr === t.x_wa) && (dmem_rqst.mask === t.x_wm) &&
                 (dmem_rqst.wdata === t.x_wd) && (fwd_hit === t.x_hit) &&
                 (fwd_stall === t.x_stl) && (fwd_data === t.x_fd);
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL vec%0d: got rdy=%b emp=%b cnt=%0d wr=%b rd=%b a=%h m=%h d=%h hit=%b stl=%b fd=%h; want rdy=%b emp=%b cnt=%0d wr=%b rd=0 a=%h m=%h d=%h hit=%b stl=%b fd=%h",
                         i, enq_ready, empty, count, dmem_rqst.wr_en, dmem_rqst.rd_en, dmem_rqst.addr,
                         dmem_rqst.mask, dmem_rqst.wdata, fwd_hit, fwd_stall, fwd_data,
                         t.x_rdy, t.x_emp, t.x_cnt, t.x_wr, t.x_wa, t.x_wm, t.x_wd, t.x_hit, t.x_stl, t.x_fd);
            end
        end

        // Two stores to one word into both instances: the coalescing one merges,
        // the non-coalescing one keeps two entries and the younger byte wins.
        @(negedge clk);
        idle_inputs();
        enq_valid    = 1'b1;
        enq_valid_nc = 1'b1;
        enq_addr     = 32'h600;
        enq_wdata    = 32'h11111111;
        enq_mask     = 4'hF;
        @(negedge clk);
        enq_wdata    = 32'h00000022;
        enq_mask     = 4'h1;
        #2;
        chk("co_ready_same_word", 32'(enq_ready), 32'h1);
        chk("nc_ready_not_full", 32'(enq_ready_nc), 32'h1);
        @(negedge clk);
        idle_inputs();
        ld_query_valid = 1'b1;
        ld_query_addr  = 32'h600;
        ld_query_mask  = 4'hF;
        #2;
        chk("nc_fwd_data", fwd_data_nc, 32'h11111122);
        chk("nc_fwd_hit", 32'(fwd_hit_nc), 32'h1);
        chk("nc_count", 32'(count_nc), 32'h2);
        chk("nc_head_wdata", dmem_rqst_nc.wdata, 32'h11111111);
        chk("co_count", 32'(count), 32'h1);
        chk("co_wdata", dmem_rqst.wdata, 32'h11111122);
        chk("co_fwd_data", fwd_data, 32'h11111122);

        // Reset while both are waiting on a write response, then a late response.
        @(negedge clk);
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dmem_resp.resp    = 1'b1;
        dmem_resp_nc.resp = 1'b1;
        #2;
        chk("rst_co_wr_en", 32'(dmem_rqst.wr_en), 32'h0);
        chk("rst_co_empty", 32'(empty), 32'h1);
        chk("rst_nc_wr_en", 32'(dmem_rqst_nc.wr_en), 32'h0);
        chk("rst_nc_empty", 32'(empty_nc), 32'h1);
        @(negedge clk);
        idle_inputs();
        #2;
        chk("late_resp_co_count", 32'(count), 32'h0);
        chk("late_resp_nc_count", 32'(count_nc), 32'h0);
        chk("late_resp_co_wr_en", 32'(dmem_rqst.wr_en), 32'h0);
        chk("late_resp_co_ready", 32'(enq_ready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
